// File: rtl/reg_file_sb.sv
// Integer register file with NREAD combinational read ports, one write port,
// x0 hardwired to zero and a per-register busy scoreboard. Optional macro
// RF_BYPASS_EN forwards a same-cycle write to matching read ports.

module rf_rd_port #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            busy,
  input  logic                       byp_hit,
  input  logic [XLEN-1:0]            byp_data,
  input  logic                       byp_busy,
  output logic [XLEN-1:0]            data,
  output logic                       busy_o
);
  always_comb begin
    data   = '0;
    busy_o = 1'b0;
    if (byp_hit) begin
      data   = byp_data;
      busy_o = byp_busy;
    end else if (addr != '0) begin
      data   = regs[addr];
      busy_o = busy[addr];
    end
  end
endmodule

module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [AW:0]           busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               busy_cnt_q, busy_cnt_d;

  logic wr_ok, iss_ok, set_new, clr_new;

  always_comb begin
    wr_ok  = we && (wa != '0);
    iss_ok = iss_valid && (iss_rd != '0);
    // Counter tracks real 0->1 and 1->0 transitions; a set on the written
    // register wins, so that write does not count as a clear.
    set_new = iss_ok && !busy_q[iss_rd];
    clr_new = wr_ok && busy_q[wa] && !(iss_ok && (iss_rd == wa));

    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wa] = wd;
      busy_d[wa] = 1'b0;
    end
    if (iss_ok) busy_d[iss_rd] = 1'b1;

    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_new};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_addr[i*AW +: AW];
`ifdef RF_BYPASS_EN
    // Gated by rst so nothing leaks out while the file is held in reset.
    assign hit = !rst && we && (wa != '0) && (wa == addr);
`else
    assign hit = 1'b0;
`endif
    rf_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_port (
      .addr    (addr),
      .regs    (regs_q),
      .busy    (busy_q),
      .byp_hit (hit),
      .byp_data(wd),
      .byp_busy(iss_valid && (iss_rd == wa)),
      .data    (rd_data[i*XLEN +: XLEN]),
      .busy_o  (rd_busy[i])
    );
  end
endmodule
